// File: rtl/wb_cache_mem_subsystem.sv
// Direct-mapped, write-back / write-allocate cache in front of a slow word-wide backing memory.
// One outstanding request; block transfers move one word every MEM_LATENCY cycles.
module wb_cache_mem_subsystem #(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 32,
    parameter int BSIZE       = 8,
    parameter int NBLKS       = 1024,
    parameter int MEM_WORDS   = 65536,
    parameter int MEM_LATENCY = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] addrFromProc,
    input  logic                  enableFromProc,
    input  logic                  writeFromProc,
    input  logic [DATA_WIDTH-1:0] dataFromProc,
    output logic [DATA_WIDTH-1:0] dataToProc,
    output logic                  readyToProc,
    output logic [31:0]           hitCount,
    output logic [31:0]           missCount,
    output logic [31:0]           writebackCount
);
    localparam int OFF_W  = $clog2(BSIZE);
    localparam int IDX_W  = $clog2(NBLKS);
    localparam int TAG_W  = ADDR_WIDTH - OFF_W - IDX_W;
    localparam int LINE_W = IDX_W + OFF_W;
    localparam int MEM_AW = $clog2(MEM_WORDS);
    localparam int CYC_W  = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;

    typedef enum logic [2:0] {IDLE, LOOKUP, WRITEBACK, FILL, RESPOND} stateType;

    stateType              stateReg, stateNext;
    logic [ADDR_WIDTH-1:0] reqAddrReg;
    logic                  reqWriteReg;
    logic [DATA_WIDTH-1:0] reqDataReg;
    logic                  missReg;
    logic [OFF_W-1:0]      wordCntReg, wordCntNext;
    logic [CYC_W-1:0]      cycCntReg, cycCntNext;
    logic [NBLKS-1:0]      validReg, dirtyReg;

    logic [TAG_W-1:0]      tagArray  [NBLKS];
    logic [DATA_WIDTH-1:0] dataArray [NBLKS*BSIZE];
    logic [DATA_WIDTH-1:0] memArray  [MEM_WORDS] = '{default: '0};
    logic [DATA_WIDTH-1:0] cacheRdData, memRdData;

    logic [TAG_W-1:0]  reqTag;
    logic [IDX_W-1:0]  reqIdx;
    logic [OFF_W-1:0]  reqOff;
    logic              lookupHit, wordEnd, lastWord, memWe;
    logic [MEM_AW-1:0] memRdIdx, memWrIdx;
    logic [LINE_W-1:0] cacheRdIdx;

    assign reqTag    = reqAddrReg[ADDR_WIDTH-1 -: TAG_W];
    assign reqIdx    = reqAddrReg[OFF_W +: IDX_W];
    assign reqOff    = reqAddrReg[OFF_W-1:0];
    assign lookupHit = validReg[reqIdx] && (tagArray[reqIdx] == reqTag);
    assign wordEnd   = (cycCntReg == CYC_W'(MEM_LATENCY - 1));
    assign lastWord  = wordEnd && (wordCntReg == OFF_W'(BSIZE - 1));

    // Read addresses follow the next-cycle word so registered reads land exactly when consumed.
    assign memRdIdx   = MEM_AW'({reqTag, reqIdx, wordCntNext});
    assign memWrIdx   = MEM_AW'({tagArray[reqIdx], reqIdx, wordCntReg});
    assign cacheRdIdx = {reqIdx, wordCntNext};
    assign memWe      = (stateReg == WRITEBACK) && wordEnd && !reset;

    always_comb begin
        stateNext   = stateReg;
        wordCntNext = '0;
        cycCntNext  = '0;
        unique case (stateReg)
            IDLE: begin
                if (enableFromProc) stateNext = LOOKUP;
            end
            LOOKUP: begin
                if (lookupHit) stateNext = RESPOND;
                else if (validReg[reqIdx] && dirtyReg[reqIdx]) stateNext = WRITEBACK;
                else stateNext = FILL;
            end
            WRITEBACK, FILL: begin
                if (!wordEnd) begin
                    cycCntNext  = cycCntReg + CYC_W'(1);
                    wordCntNext = wordCntReg;
                end else if (!lastWord) begin
                    wordCntNext = wordCntReg + OFF_W'(1);
                end else begin
                    stateNext = (stateReg == WRITEBACK) ? FILL : LOOKUP;
                end
            end
            RESPOND: stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            stateReg       <= IDLE;
            wordCntReg     <= '0;
            cycCntReg      <= '0;
            validReg       <= '0;
            dirtyReg       <= '0;
            missReg        <= 1'b0;
            dataToProc     <= '0;
            readyToProc    <= 1'b0;
            hitCount       <= '0;
            missCount      <= '0;
            writebackCount <= '0;
        end else begin
            stateReg    <= stateNext;
            wordCntReg  <= wordCntNext;
            cycCntReg   <= cycCntNext;
            readyToProc <= (stateNext == RESPOND);
            if (stateReg == IDLE && enableFromProc) missReg <= 1'b0;
            // A hit always leads straight to RESPOND, so the request is classified here.
            if (stateReg == LOOKUP) begin
                if (!lookupHit) begin
                    missReg <= 1'b1;
                end else begin
                    if (missReg) missCount <= missCount + 32'd1;
                    else         hitCount  <= hitCount + 32'd1;
                    if (reqWriteReg) dirtyReg[reqIdx] <= 1'b1;
                    else             dataToProc <= dataArray[{reqIdx, reqOff}];
                end
            end
            if (stateReg == WRITEBACK && lastWord) begin
                dirtyReg[reqIdx] <= 1'b0;
                writebackCount   <= writebackCount + 32'd1;
            end
            if (stateReg == FILL && lastWord) begin
                validReg[reqIdx] <= 1'b1;
                dirtyReg[reqIdx] <= 1'b0;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (stateReg == IDLE && enableFromProc) begin
            reqAddrReg  <= addrFromProc;
            reqWriteReg <= writeFromProc;
            reqDataReg  <= dataFromProc;
        end
    end

    // Forwarding covers a fill block that aliases the victim block in backing memory.
    always_ff @(posedge clock) begin
        cacheRdData <= dataArray[cacheRdIdx];
        memRdData   <= (memWe && memWrIdx == memRdIdx) ? cacheRdData : memArray[memRdIdx];
        if (memWe) memArray[memWrIdx] <= cacheRdData;
        if (stateReg == LOOKUP && lookupHit && reqWriteReg)
            dataArray[{reqIdx, reqOff}] <= reqDataReg;
        else if (stateReg == FILL && wordEnd)
            dataArray[{reqIdx, wordCntReg}] <= memRdData;
        if (stateReg == FILL && lastWord) tagArray[reqIdx] <= reqTag;
    end
endmodule

// File: tb/tb_wb_cache_mem_subsystem.sv
// Directed bench for the cache subsystem: BSIZE=4, NBLKS=16, MEM_LATENCY=2.
// Clean miss = 11 cycles, dirty miss = 19, hit = 2 (accept cycle to ready pulse).
module tb_wb_cache_mem_subsystem;
    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] addrFromProc = '0;
    logic        enableFromProc = 1'b0;
    logic        writeFromProc = 1'b0;
    logic [31:0] dataFromProc = '0;
    logic [31:0] dataToProc;
    logic        readyToProc;
    logic [31:0] hitCount, missCount, writebackCount;

    wb_cache_mem_subsystem #(
        .DATA_WIDTH(32), .ADDR_WIDTH(32), .BSIZE(4), .NBLKS(16),
        .MEM_WORDS(1024), .MEM_LATENCY(2)
    ) dut (
        .clock(clock), .reset(reset),
        .addrFromProc(addrFromProc), .enableFromProc(enableFromProc),
        .writeFromProc(writeFromProc), .dataFromProc(dataFromProc),
        .dataToProc(dataToProc), .readyToProc(readyToProc),
        .hitCount(hitCount), .missCount(missCount), .writebackCount(writebackCount)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] addr;
        logic        wr;
        logic [31:0] wdata;
        int          lat;
        logic [31:0] rdata;
        int          hits;
        int          misses;
        int          wbs;
    } vecType;

    vecType vecs[13];
    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Counts rising edges from the accept edge until readyToProc is seen (bounded).
    task automatic waitReady(input int startCnt, input bit dropEn, output int cycles);
        cycles = startCnt;
        do begin
            @(posedge clock);
            cycles++;
            @(negedge clock);
            if (dropEn && cycles == 1) enableFromProc = 1'b0;
        end while (!readyToProc && cycles < 100);
    endtask

    task automatic checkResp(input string name, input int lat, input int expLat,
                             input logic [31:0] expData, input int expHit,
                             input int expMiss, input int expWb);
        $display("txn %s addr=%h wr=%b lat=%0d data=%h hit=%0d miss=%0d wb=%0d",
                 name, addrFromProc, writeFromProc, lat, dataToProc, hitCount, missCount, writebackCount);
        check({name, " latency"}, 32'(lat), 32'(expLat));
        check({name, " data"}, dataToProc, expData);
        check({name, " hitCount"}, hitCount, 32'(expHit));
        check({name, " missCount"}, missCount, 32'(expMiss));
        check({name, " writebackCount"}, writebackCount, 32'(expWb));
    endtask

    task automatic pulseCheck(input string name);
        @(posedge clock);
        @(negedge clock);
        check({name, " ready pulse width"}, {31'd0, readyToProc}, 32'd0);
    endtask

    task automatic doReq(input string name, input logic [31:0] addr, input logic wr,
                         input logic [31:0] wdata, input int expLat, input logic [31:0] expData,
                         input int expHit, input int expMiss, input int expWb);
        int lat;
        addrFromProc   = addr;
        writeFromProc  = wr;
        dataFromProc   = wdata;
        enableFromProc = 1'b1;
        waitReady(0, 1'b1, lat);
        checkResp(name, lat, expLat, expData, expHit, expMiss, expWb);
        pulseCheck(name);
    endtask

    initial begin
        int lat;
        int readySeen;

        vecs[0]  = '{32'h10, 1'b0, 32'h0,        11, 32'h0,        0, 1, 0};
        vecs[1]  = '{32'h12, 1'b1, 32'hDEADBEEF,  2, 32'h0,        1, 1, 0};
        vecs[2]  = '{32'h12, 1'b0, 32'h0,         2, 32'hDEADBEEF, 2, 1, 0};
        vecs[3]  = '{32'h52, 1'b0, 32'h0,        19, 32'h0,        2, 2, 1};
        vecs[4]  = '{32'h12, 1'b0, 32'h0,        11, 32'hDEADBEEF, 2, 3, 1};
        vecs[5]  = '{32'h53, 1'b1, 32'h12345678, 11, 32'hDEADBEEF, 2, 4, 1};
        vecs[6]  = '{32'h13, 1'b0, 32'h0,        19, 32'h0,        2, 5, 2};
        vecs[7]  = '{32'h12, 1'b0, 32'h0,         2, 32'hDEADBEEF, 3, 5, 2};
        vecs[8]  = '{32'h53, 1'b0, 32'h0,        11, 32'h12345678, 3, 6, 2};
        vecs[9]  = '{32'h00, 1'b1, 32'hA5A5A5A5, 11, 32'h12345678, 3, 7, 2};
        vecs[10] = '{32'h03, 1'b0, 32'h0,         2, 32'h0,        4, 7, 2};
        vecs[11] = '{32'h3F, 1'b0, 32'h0,        11, 32'h0,        4, 8, 2};
        vecs[12] = '{32'h00, 1'b0, 32'h0,         2, 32'hA5A5A5A5, 5, 8, 2};

        repeat (3) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        check("reset ready", {31'd0, readyToProc}, 32'd0);
        check("reset data", dataToProc, 32'd0);
        check("reset hitCount", hitCount, 32'd0);
        check("reset missCount", missCount, 32'd0);
        check("reset writebackCount", writebackCount, 32'd0);

        for (int i = 0; i < 13; i++) begin
            doReq($sformatf("v%0d", i), vecs[i].addr, vecs[i].wr, vecs[i].wdata, vecs[i].lat,
                  vecs[i].rdata, vecs[i].hits, vecs[i].misses, vecs[i].wbs);
        end

        // Reset while a fill of 0x24 is in progress.
        readySeen = 0;
        addrFromProc   = 32'h24;
        writeFromProc  = 1'b0;
        enableFromProc = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clock);
            @(negedge clock);
            if (i == 0) enableFromProc = 1'b0;
            if (readyToProc) readySeen++;
        end
        reset = 1'b1;
        @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        $display("txn reset-mid-fill hit=%0d miss=%0d wb=%0d data=%h",
                 hitCount, missCount, writebackCount, dataToProc);
        check("abort data", dataToProc, 32'd0);
        check("abort hitCount", hitCount, 32'd0);
        check("abort missCount", missCount, 32'd0);
        check("abort writebackCount", writebackCount, 32'd0);
        for (int i = 0; i < 20; i++) begin
            @(posedge clock);
            @(negedge clock);
            if (readyToProc) readySeen++;
        end
        check("abort no ready", 32'(readySeen), 32'd0);
        doReq("after-abort 0x24", 32'h24, 1'b0, 32'h0, 11, 32'h0, 0, 1, 0);
        doReq("after-abort 0x00", 32'h00, 1'b0, 32'h0, 11, 32'h0, 0, 2, 0);

        // Enable held high; request inputs change while the first miss is in flight.
        addrFromProc   = 32'h34;
        writeFromProc  = 1'b0;
        dataFromProc   = 32'h0;
        enableFromProc = 1'b1;
        @(posedge clock);
        @(negedge clock);
        addrFromProc  = 32'h44;
        writeFromProc = 1'b1;
        dataFromProc  = 32'hCAFEF00D;
        waitReady(1, 1'b0, lat);
        checkResp("held-first", lat, 11, 32'h0, 0, 3, 0);
        @(posedge clock);
        @(negedge clock);
        check("held-first ready pulse width", {31'd0, readyToProc}, 32'd0);
        waitReady(0, 1'b1, lat);
        checkResp("held-second", lat, 11, 32'h0, 0, 4, 0);
        pulseCheck("held-second");
        doReq("readback 0x44", 32'h44, 1'b0, 32'h0, 2, 32'hCAFEF00D, 1, 4, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
